// File: rtl/assoc_data_cache_if.sv
// CPU request/response and memory burst signals of assoc_data_cache.
// slave is the cache side, master drives requests and serves bursts.
interface assoc_data_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  req_op;
  logic                  rw;
  logic [1:0]            mem_width;
  logic                  sign_extend;
  logic [DATA_WIDTH-1:0] write;
  logic [DATA_WIDTH-1:0] read;
  logic                  read_valid;
  logic                  ready;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic                  mem_req_op;
  logic                  mem_rw;
  logic [DATA_WIDTH-1:0] mem_read;
  logic                  mem_read_valid;
  logic [DATA_WIDTH-1:0] mem_write;
  logic                  mem_write_ready;
  logic                  mem_last;
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  modport slave (
    input  addr, req_op, rw, mem_width, sign_extend, write,
    input  mem_read, mem_read_valid, mem_write_ready, mem_last,
    output read, read_valid, ready,
    output mem_addr, mem_req_op, mem_rw, mem_write,
    output hit_count, miss_count
  );

  modport master (
    output addr, req_op, rw, mem_width, sign_extend, write,
    output mem_read, mem_read_valid, mem_write_ready, mem_last,
    input  read, read_valid, ready,
    input  mem_addr, mem_req_op, mem_rw, mem_write,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/assoc_data_cache.sv
// Set-associative write-back data cache, round-robin victim per set.
// Define DCACHE_STATS_EN to build saturating hit/miss counters.
module assoc_data_cache #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 18,
  parameter int ASSO_WIDTH         = 1,
  parameter int BLOCK_OFFSET_WIDTH = 5,
  parameter int INDEX_WIDTH        = 3
) (
  input logic               clk,
  input logic               rst_n,
  assoc_data_cache_if.slave bus
);

  localparam int TAG_W = ADDR_WIDTH - 2 - BLOCK_OFFSET_WIDTH - INDEX_WIDTH;
  localparam int WAYS  = 1 << ASSO_WIDTH;
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << BLOCK_OFFSET_WIDTH;

  localparam logic [1:0] S_READY   = 2'd0;
  localparam logic [1:0] S_WB      = 2'd1;
  localparam logic [1:0] S_REFILL  = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                          lines_q [SETS][WAYS][WORDS];
  logic [TAG_W-1:0]               tags_q  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]       valid_q, dirty_q;
  logic [SETS-1:0][ASSO_WIDTH-1:0] vptr_q;

  logic [1:0]                    state_q, state_d;
  logic [BLOCK_OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic                          rv_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic                          rw_q, sx_q;
  logic [1:0]                    mw_q;
  word_t                         wdata_q;
  logic [ASSO_WIDTH-1:0]         way_q;

  logic [TAG_W-1:0]              tag_in, rtag;
  logic [INDEX_WIDTH-1:0]        idx_in, ridx;
  logic [BLOCK_OFFSET_WIDTH-1:0] wo_in, rwo;
  logic [1:0]                    bo_in, rbo;

  assign {tag_in, idx_in, wo_in, bo_in} = bus.addr;
  assign {rtag, ridx, rwo, rbo}         = addr_q;

  function automatic word_t merge(input word_t old, input word_t wd,
                                  input logic [1:0] mw,
                                  input logic [1:0] bo);
    word_t m, s;
    case (mw)
      2'd0: begin
        m = word_t'(8'hFF) << {bo, 3'b000};
        s = word_t'(wd[7:0]) << {bo, 3'b000};
      end
      2'd1: begin
        m = word_t'(16'hFFFF) << {bo[1], 4'b0000};
        s = word_t'(wd[15:0]) << {bo[1], 4'b0000};
      end
      default: begin
        m = '1;
        s = wd;
      end
    endcase
    return (old & ~m) | (s & m);
  endfunction

  function automatic word_t fmt(input word_t d, input logic [1:0] mw,
                                input logic [1:0] bo, input logic sx);
    word_t b, h;
    b = d >> {bo, 3'b000};
    h = d >> {bo[1], 4'b0000};
    case (mw)
      2'd0:    return {{(DATA_WIDTH-8){sx & b[7]}}, b[7:0]};
      2'd1:    return {{(DATA_WIDTH-16){sx & h[15]}}, h[15:0]};
      default: return d;
    endcase
  endfunction

  logic                  hit, accept, vdirty;
  logic [ASSO_WIDTH-1:0] hway, victim;

  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_in][ASSO_WIDTH'(w)] &&
          tags_q[idx_in][ASSO_WIDTH'(w)] == tag_in) begin
        hit  = 1'b1;
        hway = ASSO_WIDTH'(w);
      end
    end
  end

  assign accept = bus.req_op && (state_q == S_READY);
  assign victim = vptr_q[idx_in];
  assign vdirty = valid_q[idx_in][victim] && dirty_q[idx_in][victim];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_READY: begin
        cnt_d = '0;
        if (accept && !hit) state_d = vdirty ? S_WB : S_REFILL;
      end
      S_WB: if (bus.mem_write_ready) begin
        cnt_d = bus.mem_last ? '0 : cnt_q + 1'b1;
        if (bus.mem_last) state_d = S_REFILL;
      end
      S_REFILL: if (bus.mem_read_valid) begin
        cnt_d = bus.mem_last ? '0 : cnt_q + 1'b1;
        if (bus.mem_last) state_d = S_RESPOND;
      end
      default: state_d = S_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_READY;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
      vptr_q  <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      sx_q    <= 1'b0;
      mw_q    <= 2'd0;
      wdata_q <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= accept && hit && !bus.rw;
      if (accept) begin
        addr_q  <= bus.addr;
        rw_q    <= bus.rw;
        sx_q    <= bus.sign_extend;
        mw_q    <= bus.mem_width;
        wdata_q <= bus.write;
        way_q   <= hit ? hway : victim;
        if (!hit) vptr_q[idx_in] <= victim + 1'b1;
        if (hit && bus.rw) dirty_q[idx_in][hway] <= 1'b1;
      end
      if (state_q == S_REFILL && bus.mem_read_valid && bus.mem_last) begin
        valid_q[ridx][way_q] <= 1'b1;
        dirty_q[ridx][way_q] <= 1'b0;
      end
      if (state_q == S_RESPOND && rw_q) dirty_q[ridx][way_q] <= 1'b1;
    end
  end

  // Line data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (accept && hit && bus.rw)
      lines_q[idx_in][hway][wo_in] <= merge(lines_q[idx_in][hway][wo_in],
                                            bus.write, bus.mem_width, bo_in);
    if (state_q == S_REFILL && bus.mem_read_valid) begin
      lines_q[ridx][way_q][cnt_q] <= bus.mem_read;
      if (bus.mem_last) tags_q[ridx][way_q] <= rtag;
    end
    if (state_q == S_RESPOND && rw_q)
      lines_q[ridx][way_q][rwo] <= merge(lines_q[ridx][way_q][rwo],
                                         wdata_q, mw_q, rbo);
  end

  assign bus.ready      = (state_q == S_READY);
  assign bus.read_valid = rv_q || (state_q == S_RESPOND && !rw_q);
  assign bus.read       = fmt(lines_q[ridx][way_q][rwo], mw_q, rbo, sx_q);
  assign bus.mem_req_op = (state_q == S_WB) || (state_q == S_REFILL);
  assign bus.mem_rw     = (state_q == S_WB);
  assign bus.mem_write  = lines_q[ridx][way_q][cnt_q];
  assign bus.mem_addr   = (state_q == S_WB) ?
    {tags_q[ridx][way_q], ridx, {BLOCK_OFFSET_WIDTH{1'b0}}} :
    {rtag, ridx, {BLOCK_OFFSET_WIDTH{1'b0}}};

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q <= '0;
      miss_q <= '0;
    end else if (accept) begin
      if (hit && hits_q != '1) hits_q <= hits_q + 1'b1;
      if (!hit && miss_q != '1) miss_q <= miss_q + 1'b1;
    end
  end

  assign bus.hit_count  = hits_q;
  assign bus.miss_count = miss_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed bench for assoc_data_cache with a burst memory model
// and a queue of expected load results.
module tb_assoc_data_cache;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assoc_data_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(18)) bus ();

  assoc_data_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] d;
    string       t;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          hits_e = 0;
  int          miss_e = 0;
  logic [31:0] mem [65536];

  int          beat = 0;
  logic        hs_q = 1'b0;
  logic        last_q = 1'b0;
  int          rf_bursts = 0;
  int          wb_bursts = 0;
  logic [15:0] burst_addr = '0;
  logic [31:0] rf_addr = '0, rf_beats = '0;
  logic [31:0] wb_addr = '0, wb_beats = '0;

  task automatic chk(input string t, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  // Burst memory: drives one beat per cycle, accounts consumption next negedge.
  always @(negedge clk) begin
    if (!rst_n || bus.mem_req_op !== 1'b1) begin
      beat                = 0;
      hs_q                = 1'b0;
      bus.mem_read_valid  = 1'b0;
      bus.mem_write_ready = 1'b0;
      bus.mem_last        = 1'b0;
      bus.mem_read        = '0;
    end else begin
      if (hs_q) beat = last_q ? 0 : beat + 1;
      if (beat == 0) begin
        burst_addr = bus.mem_addr;
        if (bus.mem_rw) wb_bursts++;
        else rf_bursts++;
      end
      bus.mem_last = (beat == 31);
      if (bus.mem_rw) begin
        bus.mem_write_ready = 1'b1;
        bus.mem_read_valid  = 1'b0;
        mem[16'(burst_addr + 16'(beat))] = bus.mem_write;
      end else begin
        bus.mem_write_ready = 1'b0;
        bus.mem_read_valid  = 1'b1;
        bus.mem_read        = mem[16'(burst_addr + 16'(beat))];
      end
      if (bus.mem_last) begin
        if (bus.mem_rw) begin
          wb_addr  = 32'(burst_addr);
          wb_beats = 32'(beat + 1);
        end else begin
          rf_addr  = 32'(burst_addr);
          rf_beats = 32'(beat + 1);
        end
      end
      hs_q   = 1'b1;
      last_q = bus.mem_last;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.read_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_rv: got read %h expected no load", bus.read);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.t, "_data"}, bus.read, e.d);
      end
    end
  end

  task automatic req(input string t, input logic [17:0] a,
                     input logic w, input logic [1:0] mw,
                     input logic sx, input logic [31:0] wd,
                     input logic exp_hit, input logic [31:0] exp_rd);
    int n;
    exp_t e;
    @(negedge clk);
    bus.addr        = a;
    bus.rw          = w;
    bus.mem_width   = mw;
    bus.sign_extend = sx;
    bus.write       = wd;
    bus.req_op      = 1'b1;
    chk({t, "_ready"}, 32'(bus.ready), 32'd1);
    if (!w) begin
      e.d = exp_rd;
      e.t = t;
      sb.push_back(e);
    end
    if (exp_hit) hits_e++;
    else miss_e++;
    @(negedge clk);
    bus.req_op = 1'b0;
    if (exp_hit)
      chk({t, "_lat"}, {30'd0, bus.read_valid, bus.ready}, {30'd0, !w, 1'b1});
    else
      chk({t, "_miss"}, 32'(bus.ready), 32'd0);
    #1;
    n = 0;
    while ((sb.size() != 0 || bus.ready !== 1'b1) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({t, "_done"}, 32'(n < 300), 32'd1);
  endtask

  task automatic stats(input string t);
`ifdef DCACHE_STATS_EN
    chk({t, "_hits"}, bus.hit_count, 32'(hits_e));
    chk({t, "_miss"}, bus.miss_count, 32'(miss_e));
`else
    chk({t, "_hits"}, bus.hit_count, 32'd0);
    chk({t, "_miss"}, bus.miss_count, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rb;
    for (int i = 0; i < 65536; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[16'h0040] = 32'h80FF_1234;
    bus.addr        = '0;
    bus.req_op      = 1'b0;
    bus.rw          = 1'b0;
    bus.mem_width   = 2'd2;
    bus.sign_extend = 1'b0;
    bus.write       = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_memreq", 32'(bus.mem_req_op), 32'd0);
    chk("rst_memrw", 32'(bus.mem_rw), 32'd0);
    chk("rst_rv", 32'(bus.read_valid), 32'd0);
    stats("rst");
    @(negedge clk);
    rst_n = 1'b1;

    req("rd_miss", 18'h00100, 1'b0, 2'd2, 1'b0, '0, 1'b0, 32'h80FF_1234);
    chk("rf_addr", rf_addr, 32'h40);
    chk("rf_beats", rf_beats, 32'd32);
    req("rd_b_sx", 18'h00103, 1'b0, 2'd0, 1'b1, '0, 1'b1, 32'hFFFF_FF80);
    req("rd_b_zx", 18'h00103, 1'b0, 2'd0, 1'b0, '0, 1'b1, 32'h0000_0080);
    req("rd_h_sx", 18'h00102, 1'b0, 2'd1, 1'b1, '0, 1'b1, 32'hFFFF_80FF);
    req("rd_h_lo", 18'h00100, 1'b0, 2'd1, 1'b1, '0, 1'b1, 32'h0000_1234);
    req("wr_half", 18'h00102, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 1'b1, '0);
    req("rd_merge", 18'h00100, 1'b0, 2'd2, 1'b0, '0, 1'b1, 32'hBEEF_1234);
    req("wr_byte", 18'h00101, 1'b1, 2'd0, 1'b0, 32'hAAAA_AA55, 1'b1, '0);
    req("rd_wd_ign", 18'h00103, 1'b0, 2'd2, 1'b1, '0, 1'b1, 32'hBEEF_5534);
    stats("mid1");

    req("wr_t0", 18'h00000, 1'b1, 2'd2, 1'b0, 32'h1111_0000, 1'b0, '0);
    req("wr_t1", 18'h00400, 1'b1, 2'd2, 1'b0, 32'h2222_0000, 1'b0, '0);
    chk("no_wb_clean", 32'(wb_bursts), 32'd0);
    req("rd_t2", 18'h00800, 1'b0, 2'd2, 1'b0, '0, 1'b0, 32'hC0DE_0200);
    chk("wb_count", 32'(wb_bursts), 32'd1);
    chk("wb_addr", wb_addr, 32'h0);
    chk("wb_beats", wb_beats, 32'd32);
    chk("wb_word0", mem[0], 32'h1111_0000);
    chk("wb_word1", mem[1], 32'hC0DE_0001);
    chk("rf_addr2", rf_addr, 32'h200);
    req("rd_t1_hit", 18'h00400, 1'b0, 2'd2, 1'b0, '0, 1'b1, 32'h2222_0000);
    stats("mid2");

    @(negedge clk);
    bus.addr      = 18'h01100;
    bus.rw        = 1'b0;
    bus.mem_width = 2'd2;
    bus.req_op    = 1'b1;
    @(negedge clk);
    bus.req_op = 1'b0;
    n = 0;
    #1;
    while (!(bus.mem_req_op === 1'b1 && bus.mem_rw === 1'b0 && beat == 10)
           && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_reach", 32'(n < 100), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_memreq", 32'(bus.mem_req_op), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    hits_e = 0;
    miss_e = 0;
    stats("abort");
    @(negedge clk);
    rst_n = 1'b1;

    rb = rf_bursts;
    req("re_miss", 18'h01100, 1'b0, 2'd2, 1'b0, '0, 1'b0, 32'hC0DE_0440);
    chk("re_refill", 32'(rf_bursts), 32'(rb + 1));
    req("re_hit1", 18'h01104, 1'b0, 2'd2, 1'b0, '0, 1'b1, 32'hC0DE_0441);
    req("re_hit2", 18'h01100, 1'b0, 2'd2, 1'b0, '0, 1'b1, 32'hC0DE_0440);
    req("drop_dirty", 18'h00100, 1'b0, 2'd2, 1'b0, '0, 1'b0, 32'h80FF_1234);
    req("re_hit3", 18'h00100, 1'b0, 2'd2, 1'b0, '0, 1'b1, 32'h80FF_1234);
    stats("final");

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/assoc_data_cache.md
ASSOC_DATA_CACHE -- requirements
Module: assoc_data_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, 18, CPU byte-address width.
REQ-003 SHALL have parameter ASSO_WIDTH, 1, log2 of ways per set.
REQ-004 SHALL have parameter BLOCK_OFFSET_WIDTH, 5, log2 of words per line.
REQ-005 SHALL have parameter INDEX_WIDTH, 3, log2 of sets.
REQ-006 SHALL have ports, clock and reset first. The single clock is clk and the asynchronous active-low reset is rst_n:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_WIDTH  byte address
- req_op  in  1  request strobe
- rw  in  1  1=write, 0=read
- mem_width  in  2  0=byte, 1=half, 2=word
- sign_extend  in  1  sign-extend byte/half reads
- write  in  DATA_WIDTH  store data, LSB-aligned
- read  out  DATA_WIDTH  load data
- read_valid  out  1  load data valid, one cycle
- ready  out  1  request accepted this cycle
- mem_addr  out  ADDR_WIDTH-2  word address for the burst
- mem_req_op  out  1  burst active
- mem_rw  out  1  1=write burst
- mem_read  in  DATA_WIDTH  refill word
- mem_read_valid  in  1  refill word valid
- mem_write  out  DATA_WIDTH  writeback word
- mem_write_ready  in  1  writeback word consumed
- mem_last  in  1  final beat of the burst
- hit_count, miss_count  out  32  statistics counters

Function
REQ-007 Address split SHALL be tag | index | word offset | byte offset(2); tag width = ADDR_WIDTH-2-BLOCK_OFFSET_WIDTH-INDEX_WIDTH.
REQ-008 Storage SHALL be per set and way: tag, valid bit, dirty bit, 2^BLOCK_OFFSET_WIDTH data words; each set SHALL also hold a round-robin victim pointer of ASSO_WIDTH bits.
REQ-009 FSM states SHALL be READY, WRITEBACK, REFILL and RESPOND; ready=1 only in READY.
REQ-010 A request SHALL be accepted when req_op&&ready; all request fields SHALL be latched on acceptance.
REQ-011 A read hit SHALL assert read_valid with data on the cycle after acceptance, with no state change.
REQ-012 A write hit SHALL merge bytes selected by mem_width and addr[1:0] into the line and set dirty on the accepting edge.
REQ-013 Read data SHALL be the selected byte or half shifted to the LSB, zero-extended or sign-extended per sign_extend; a word access SHALL ignore addr[1:0].
REQ-014 On a miss, the victim SHALL be the way at the set's victim pointer; the pointer SHALL advance modulo ways.
REQ-015 Miss with a dirty victim SHALL go to WRITEBACK:
- mem_req_op=1, mem_rw=1
- mem_addr = victim tag/index with word offset 0
- mem_write = line word[cnt]; cnt increments on mem_write_ready
- mem_write_ready&&mem_last SHALL go to REFILL.
REQ-016 Miss with a clean or invalid victim SHALL go directly to REFILL.
REQ-017 REFILL SHALL drive mem_req_op=1 and mem_rw=0, with mem_addr = request tag/index, offset 0.
- each mem_read_valid writes word[cnt], cnt++
- mem_read_valid&&mem_last SHALL write tag, set valid, clear dirty, go to RESPOND.
REQ-018 RESPOND SHALL complete the latched access as a hit (a read asserts read_valid that cycle; a write sets dirty) and return to READY; mem_req_op=0 outside WRITEBACK and REFILL.
REQ-019 mem_last before 2^BLOCK_OFFSET_WIDTH beats SHALL end the burst; unfilled words are undefined. The word counter SHALL wrap modulo line size.
REQ-020 Requests while ready=0 SHALL be ignored.

Reset
REQ-021 Reset SHALL clear state to READY, read_valid, mem_req_op, mem_rw, all valid/dirty bits, victim pointers, counters and the word counter to 0; data/tag arrays are not reset.
REQ-022 Reset asserted mid-burst SHALL abort it immediately, drop mem_req_op and discard dirty data.

Configuration
REQ-023 With DCACHE_STATS_EN defined, hit_count/miss_count SHALL increment by one per accepted hit/miss and saturate at 2^32-1; without it they SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-024 Read 0x00100 after reset -> miss, REFILL at mem_addr 0x0040, 32 beats, read_valid with word 0 in RESPOND.
REQ-025 Byte read 0x00103 of line word 0x80FF_1234 with sign_extend=1 -> read=0xFFFF_FF80; with sign_extend=0 -> 0x0000_0080.
REQ-026 Half write 0xBEEF at 0x00102 then word read 0x00100 -> hit, read=0xBEEF_xxxx with the low half unchanged, read_valid one cycle after acceptance.
REQ-027 Dirty line in both ways of set 0, third tag miss -> WRITEBACK of the way-0 line (32 beats, mem_rw=1), then REFILL.
REQ-028 rst_n low during beat 10 of REFILL -> mem_req_op=0 at once, ready=1; a later read of that address misses.
REQ-029 With DCACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2; without it both read 0.
